// File: rtl/io_output_seq.sv
// ---------------------------------------------------------------------------
// io_output_seq
//
// Buffered output sequencer for the I/O unit. A number held in ac/au is
// serialised into one sign code, N digit codes and one end code. The codes
// go through a small FIFO and are sent to the printer/punch over a
// four-phase rdy/ack handshake. When the last code has left, the sequencer
// returns to idle and, unless stop_after_output is set, issues one start
// pulse to pu.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   start_output             pulse: begin a number (idle only)
//   stop_output              pulse: abort the running sequence
//   mode_oct, mode_dec       level: mode, sampled on an accepted start
//   stop_after_output        level: suppress the start pulse at the end
//   output_sign_from_ac      sign bit, read when the sign code is pushed
//   output_data_from_au[3:0] digit, valid with ac_answer_from_ac
//   order_io_to_ac           one-cycle request for the next digit shift
//   ac_answer_from_ac        pulse: digit valid
//   shift_3_bit_to_ac        level: active && octal
//   shift_4_bit_to_ac        level: active && decimal
//   output_active            level: sequence in progress
//   output_rdy_to_dev        handshake request to the device
//   output_ack_from_dev      handshake acknowledge from the device
//   output_data_to_dev[4:0]  FIFO head code (0 when the FIFO is empty)
//   start_pulse_to_pu        one-cycle pulse when a sequence finishes
//   fifo_level               occupied FIFO entries
//   dbg_p_state, dbg_d_state current producer / device FSM states
//
// Device handshake (four-phase): rdy rises while data holds the FIFO head;
// the device raises ack once it has taken the code; rdy then drops while
// data stays stable; when ack falls the head is popped. rdy is therefore
// low for at least one cycle between two codes.
// ---------------------------------------------------------------------------
module io_output_seq #(
  parameter int unsigned OCT_DIGITS = 10,
  parameter int unsigned DEC_DIGITS = 7,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [4:0]  END_CODE   = 5'b00110,
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_output,
  input  logic          stop_output,
  input  logic          mode_oct,
  input  logic          mode_dec,
  input  logic          stop_after_output,
  input  logic          output_sign_from_ac,
  input  logic [3:0]    output_data_from_au,
  output logic          order_io_to_ac,
  input  logic          ac_answer_from_ac,
  output logic          shift_3_bit_to_ac,
  output logic          shift_4_bit_to_ac,
  output logic          output_active,
  output logic          output_rdy_to_dev,
  input  logic          output_ack_from_dev,
  output logic [4:0]    output_data_to_dev,
  output logic          start_pulse_to_pu,
  output logic [LW-1:0] fifo_level,
  output logic [2:0]    dbg_p_state,
  output logic [1:0]    dbg_d_state
);

  typedef enum logic [2:0] {
    P_IDLE  = 3'd0,
    P_SIGN  = 3'd1,
    P_REQ   = 3'd2,
    P_WAIT  = 3'd3,
    P_NUM   = 3'd4,
    P_END   = 3'd5,
    P_DRAIN = 3'd6
  } p_state_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_RDY  = 2'd1,
    D_ACK  = 2'd2
  } d_state_t;

  p_state_t r_p_state, w_p_next;
  d_state_t r_d_state, w_d_next;

  logic          r_mode_oct;
  logic          r_mode_dec;
  logic          r_active;
  logic          r_start_pulse;
  logic [3:0]    r_cnt;
  logic [3:0]    r_n;
  logic [3:0]    r_digit;
  logic          r_discard;
  logic [4:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic       w_full;
  logic       w_empty;
  logic       w_abort;
  logic       w_accept;
  logic       w_push;
  logic [4:0] w_push_code;
  logic       w_pop;
  logic       w_order;
  logic       w_capture;
  logic       w_finish;

  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_abort = stop_output && (r_p_state != P_IDLE);
  // A simultaneous stop cancels the start even when idle.
  assign w_accept = (r_p_state == P_IDLE) && start_output && !stop_output &&
                    (mode_oct || mode_dec);

  // Producer: next state and per-cycle controls.
  always_comb begin
    w_p_next    = r_p_state;
    w_push      = 1'b0;
    w_push_code = 5'd0;
    w_order     = 1'b0;
    w_capture   = 1'b0;
    w_finish    = 1'b0;
    case (r_p_state)
      P_IDLE: if (w_accept) w_p_next = P_SIGN;
      P_SIGN: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_code = {4'b1111, output_sign_from_ac};
          w_p_next    = P_REQ;
        end
      end
      // No digit is fetched while the FIFO is full; the producer waits here.
      P_REQ: begin
        if (!w_full) begin
          w_order  = 1'b1;
          w_p_next = P_WAIT;
        end
      end
      P_WAIT: begin
        if (ac_answer_from_ac) begin
          w_capture = 1'b1;
          w_p_next  = P_NUM;
        end
      end
      P_NUM: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_code = r_mode_oct ? {2'b10, r_digit[3:1]} : {1'b1, r_digit};
          w_p_next    = ((r_cnt + 4'd1) == r_n) ? P_END : P_REQ;
        end
      end
      P_END: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_code = END_CODE;
          w_p_next    = P_DRAIN;
        end
      end
      P_DRAIN: begin
        if (w_empty && (r_d_state == D_IDLE)) begin
          w_finish = 1'b1;
          w_p_next = P_IDLE;
        end
      end
      default: w_p_next = P_IDLE;
    endcase
    if (w_abort) begin
      w_p_next  = P_IDLE;
      w_push    = 1'b0;
      w_order   = 1'b0;
      w_capture = 1'b0;
      w_finish  = 1'b0;
    end
  end

  // Device side: next state and pop.
  always_comb begin
    w_d_next = r_d_state;
    w_pop    = 1'b0;
    case (r_d_state)
      D_IDLE: if (!w_empty) w_d_next = D_RDY;
      D_RDY:  if (output_ack_from_dev) w_d_next = D_ACK;
      D_ACK: begin
        if (!output_ack_from_dev) begin
          w_d_next = D_IDLE;
          w_pop    = !r_discard;
        end
      end
      default: w_d_next = D_IDLE;
    endcase
    // An abort flushes the FIFO; a transfer already acknowledged still
    // completes its handshake, but nothing is popped.
    if (w_abort) begin
      w_pop = 1'b0;
      if (r_d_state != D_ACK) w_d_next = D_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p_state <= P_IDLE;
      r_d_state <= D_IDLE;
    end else begin
      r_p_state <= w_p_next;
      r_d_state <= w_d_next;
    end
  end

  // Sequence control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_oct    <= 1'b0;
      r_mode_dec    <= 1'b0;
      r_active      <= 1'b0;
      r_start_pulse <= 1'b0;
      r_cnt         <= 4'd0;
      r_n           <= 4'd0;
      r_digit       <= 4'd0;
      r_discard     <= 1'b0;
    end else begin
      r_start_pulse <= w_finish && !stop_after_output;
      if (w_abort || w_finish) begin
        r_active <= 1'b0;
      end else if (w_accept) begin
        r_active   <= 1'b1;
        // Octal has priority when both modes are requested.
        r_mode_oct <= mode_oct;
        r_mode_dec <= !mode_oct;
        r_n        <= mode_oct ? 4'(OCT_DIGITS) : 4'(DEC_DIGITS);
        r_cnt      <= 4'd0;
      end
      if (w_push && (r_p_state == P_NUM)) r_cnt <= r_cnt + 4'd1;
      if (w_capture) r_digit <= output_data_from_au;
      if (w_abort && (r_d_state == D_ACK) && (w_d_next == D_ACK)) begin
        r_discard <= 1'b1;
      end else if (w_d_next != D_ACK) begin
        r_discard <= 1'b0;
      end
    end
  end

  // Code FIFO. Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || w_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_code;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign order_io_to_ac     = w_order;
  assign shift_3_bit_to_ac  = r_active && r_mode_oct;
  assign shift_4_bit_to_ac  = r_active && r_mode_dec;
  assign output_active      = r_active;
  assign output_rdy_to_dev  = (r_d_state == D_RDY);
  assign output_data_to_dev = w_empty ? 5'd0 : r_mem[r_rd_ptr];
  assign start_pulse_to_pu  = r_start_pulse;
  assign fifo_level         = r_level;
  assign dbg_p_state        = r_p_state;
  assign dbg_d_state        = r_d_state;

endmodule

// File: tb/tb_io_output_seq.sv
// ---------------------------------------------------------------------------
// tb_io_output_seq
//
// Directed bench for io_output_seq with default parameters (10 octal
// digits, 7 decimal digits, 4-entry FIFO, end code 00110). An ac model
// answers every order_io two cycles later with the next digit of dig_tab;
// a device model takes codes over the rdy/ack handshake (or the ack is
// driven by hand). Expected code streams are built from dig_tab.
// ---------------------------------------------------------------------------
module tb_io_output_seq;

  localparam int unsigned FD       = 4;
  localparam logic [4:0]  END_CODE = 5'b00110;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_output, stop_output, mode_oct, mode_dec;
  logic       stop_after_output, output_sign_from_ac;
  logic [3:0] output_data_from_au;
  logic       order_io_to_ac, ac_answer_from_ac;
  logic       shift_3_bit_to_ac, shift_4_bit_to_ac, output_active;
  logic       output_rdy_to_dev, w_ack;
  logic [4:0] output_data_to_dev;
  logic       start_pulse_to_pu;
  logic [2:0] fifo_level;
  logic [2:0] dbg_p_state;
  logic [1:0] dbg_d_state;

  // Device ack: automatic model or manual control from the test sequence.
  logic dev_auto, auto_ack, man_ack;
  int   dev_hold;
  assign w_ack = dev_auto ? auto_ack : man_ack;

  io_output_seq dut (
    .clk                 (clk),
    .reset               (reset),
    .start_output        (start_output),
    .stop_output         (stop_output),
    .mode_oct            (mode_oct),
    .mode_dec            (mode_dec),
    .stop_after_output   (stop_after_output),
    .output_sign_from_ac (output_sign_from_ac),
    .output_data_from_au (output_data_from_au),
    .order_io_to_ac      (order_io_to_ac),
    .ac_answer_from_ac   (ac_answer_from_ac),
    .shift_3_bit_to_ac   (shift_3_bit_to_ac),
    .shift_4_bit_to_ac   (shift_4_bit_to_ac),
    .output_active       (output_active),
    .output_rdy_to_dev   (output_rdy_to_dev),
    .output_ack_from_dev (w_ack),
    .output_data_to_dev  (output_data_to_dev),
    .start_pulse_to_pu   (start_pulse_to_pu),
    .fifo_level          (fifo_level),
    .dbg_p_state         (dbg_p_state),
    .dbg_d_state         (dbg_d_state)
  );

  // Scoreboard state
  logic [4:0] exp_q[$];
  logic [4:0] rx_q[$];
  logic [3:0] dig_tab[16];
  int         rx_base;
  int         n_cmp = 0;
  int         n_err = 0;

  // Monitor-owned counters
  int order_cnt = 0, start_cnt = 0, full_order = 0;
  int shift_viol = 0, pulse_viol = 0, max_level = 0;
  bit exp_oct;

  // ac model counters
  int ac_cnt = 0;
  int ac_base;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ac model: answer each order_io two cycles later.
  initial begin
    ac_answer_from_ac   = 1'b0;
    output_data_from_au = 4'd0;
    forever begin
      @(negedge clk);
      if (order_io_to_ac) begin
        output_data_from_au = dig_tab[(ac_cnt - ac_base) & 15];
        ac_cnt++;
        repeat (2) @(negedge clk);
        ac_answer_from_ac = 1'b1;
        @(negedge clk);
        ac_answer_from_ac = 1'b0;
      end
    end
  end

  // Device model: record the code, ack, release ack once rdy has dropped.
  initial begin
    auto_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (dev_auto && output_rdy_to_dev && !auto_ack) begin
        if (dev_hold > 0) repeat (dev_hold) @(negedge clk);
        rx_q.push_back(output_data_to_dev);
        auto_ack = 1'b1;
        for (int k = 0; k < 50 && output_rdy_to_dev; k++) @(negedge clk);
        auto_ack = 1'b0;
      end
    end
  end

  // Monitor
  logic prev_order = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (order_io_to_ac) order_cnt++;
      if (start_pulse_to_pu) start_cnt++;
      if (order_io_to_ac && (fifo_level == 3'(FD))) full_order++;
      if (order_io_to_ac && prev_order) pulse_viol++;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (output_active) begin
        if (shift_3_bit_to_ac != exp_oct || shift_4_bit_to_ac != !exp_oct) shift_viol++;
      end else if (shift_3_bit_to_ac || shift_4_bit_to_ac) begin
        shift_viol++;
      end
    end
    prev_order = order_io_to_ac;
  end

  // Driver tasks
  task automatic prep_run(input bit oct, input bit sign, input int n);
    exp_q.delete();
    rx_base = rx_q.size();
    ac_base = ac_cnt;
    exp_oct = oct;
    exp_q.push_back({4'b1111, sign});
    for (int i = 0; i < n; i++) begin
      if (oct) exp_q.push_back({2'b10, dig_tab[i][3:1]});
      else     exp_q.push_back({1'b1, dig_tab[i]});
    end
    exp_q.push_back(END_CODE);
  endtask

  task automatic start_number(input bit oct, input bit dec, input bit sign, input bit sap);
    @(negedge clk);
    mode_oct            = oct;
    mode_dec            = dec;
    output_sign_from_ac = sign;
    stop_after_output   = sap;
    start_output        = 1'b1;
    @(negedge clk);
    start_output = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (output_active && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, output_active, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic cmp_codes(input string tag);
    int n;
    n = rx_q.size() - rx_base;
    chk({tag, "_count"}, n, exp_q.size());
    foreach (exp_q[i]) begin
      chk($sformatf("%s_code%0d", tag, i),
          (i < n) ? 32'(rx_q[rx_base + i]) : 32'hffff_ffff, 32'(exp_q[i]));
    end
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int o0, s0;

  initial begin
    reset = 1'b1; start_output = 1'b0; stop_output = 1'b0;
    mode_oct = 1'b0; mode_dec = 1'b0; stop_after_output = 1'b0;
    output_sign_from_ac = 1'b0; dev_auto = 1'b1; man_ack = 1'b0;
    dev_hold = 0; exp_oct = 1'b0; ac_base = 0; rx_base = 0;
    foreach (dig_tab[i]) dig_tab[i] = 4'd0;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_order", order_io_to_ac, 0);
    chk("rst_sh3", shift_3_bit_to_ac, 0);
    chk("rst_sh4", shift_4_bit_to_ac, 0);
    chk("rst_active", output_active, 0);
    chk("rst_rdy", output_rdy_to_dev, 0);
    chk("rst_data", output_data_to_dev, 0);
    chk("rst_pulse", start_pulse_to_pu, 0);
    chk("rst_level", fifo_level, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: decimal, sign 1, digits 1..7, with start latency checks
    for (int i = 0; i < 7; i++) dig_tab[i] = 4'(i + 1);
    prep_run(1'b0, 1'b1, 7);
    o0 = order_cnt; s0 = start_cnt;
    start_number(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t1_active_c1", output_active, 1);
    chk("t1_level_c1", fifo_level, 0);
    @(negedge clk);
    chk("t1_level_c2", fifo_level, 1);
    chk("t1_rdy_c2", output_rdy_to_dev, 0);
    @(negedge clk);
    chk("t1_rdy_c3", output_rdy_to_dev, 1);
    chk("t1_data_c3", output_data_to_dev, 5'b11111);
    wait_done("t1");
    cmp_codes("t1");
    chk("t1_orders", order_cnt - o0, 7);
    chk("t1_pulses", start_cnt - s0, 1);
    chk("t1_active_end", output_active, 0);

    // 2: octal (both modes high, octal wins), sign 0, digits 1110
    for (int i = 0; i < 10; i++) dig_tab[i] = 4'b1110;
    prep_run(1'b1, 1'b0, 10);
    o0 = order_cnt; s0 = start_cnt;
    start_number(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("t2_sh3", shift_3_bit_to_ac, 1);
    chk("t2_sh4", shift_4_bit_to_ac, 0);
    wait_done("t2");
    cmp_codes("t2");
    chk("t2_orders", order_cnt - o0, 10);
    chk("t2_pulses", start_cnt - s0, 1);

    // 3: device holds ack off for 50 cycles; FIFO fills and producer stalls
    for (int i = 0; i < 7; i++) dig_tab[i] = 4'(9 - i);
    prep_run(1'b0, 1'b0, 7);
    o0 = order_cnt; s0 = start_cnt;
    dev_hold = 50;
    start_number(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (38) @(negedge clk);
    chk("t3_level_full", fifo_level, FD);
    chk("t3_orders_stalled", order_cnt - o0, 3);
    chk("t3_head", output_data_to_dev, 5'b11110);
    dev_hold = 0;
    wait_done("t3");
    cmp_codes("t3");
    chk("t3_pulses", start_cnt - s0, 1);

    // 4: abort while the device is in its ack phase with 3 codes queued
    for (int i = 0; i < 7; i++) dig_tab[i] = 4'(i + 1);
    prep_run(1'b0, 1'b1, 7);
    s0 = start_cnt;
    dev_auto = 1'b0;
    start_number(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 50 && !output_rdy_to_dev; k++) @(negedge clk);
    chk("t4_rdy", output_rdy_to_dev, 1);
    man_ack = 1'b1;
    for (int k = 0; k < 100 && fifo_level != 3'd3; k++) @(negedge clk);
    chk("t4_level3", fifo_level, 3);
    chk("t4_rdy_in_ack", output_rdy_to_dev, 0);
    stop_output = 1'b1;
    @(negedge clk);
    stop_output = 1'b0;
    chk("t4_level_flushed", fifo_level, 0);
    chk("t4_active_clr", output_active, 0);
    repeat (3) @(negedge clk);
    chk("t4_rdy_ack_high", output_rdy_to_dev, 0);
    man_ack = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_rdy_after", output_rdy_to_dev, 0);
    chk("t4_data_after", output_data_to_dev, 0);
    chk("t4_level_after", fifo_level, 0);
    chk("t4_no_pulse", start_cnt - s0, 0);
    repeat (10) @(negedge clk);
    dev_auto = 1'b1;
    prep_run(1'b0, 1'b0, 7);
    s0 = start_cnt;
    start_number(1'b0, 1'b1, 1'b0, 1'b0);
    wait_done("t4b");
    cmp_codes("t4b");
    chk("t4b_pulses", start_cnt - s0, 1);

    // 5: stop_after_output suppresses the start pulse
    dig_tab[0] = 4'h0; dig_tab[1] = 4'h9; dig_tab[2] = 4'hF; dig_tab[3] = 4'h8;
    dig_tab[4] = 4'h3; dig_tab[5] = 4'hA; dig_tab[6] = 4'h5;
    prep_run(1'b0, 1'b0, 7);
    s0 = start_cnt;
    start_number(1'b0, 1'b1, 1'b0, 1'b1);
    wait_done("t5");
    cmp_codes("t5");
    chk("t5_no_pulse", start_cnt - s0, 0);

    // 6a: start with no mode selected is ignored
    o0 = order_cnt;
    rx_base = rx_q.size();
    start_number(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("t6a_active", output_active, 0);
    chk("t6a_orders", order_cnt - o0, 0);
    chk("t6a_codes", rx_q.size() - rx_base, 0);
    chk("t6a_level", fifo_level, 0);

    // 6b: start during an active run (and mode change) is ignored
    for (int i = 0; i < 7; i++) dig_tab[i] = 4'(7 - i);
    prep_run(1'b0, 1'b1, 7);
    o0 = order_cnt; s0 = start_cnt;
    start_number(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    start_number(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done("t6b");
    cmp_codes("t6b");
    chk("t6b_orders", order_cnt - o0, 7);
    chk("t6b_pulses", start_cnt - s0, 1);

    // Whole-run monitors
    chk("mon_shift", shift_viol, 0);
    chk("mon_order_full", full_order, 0);
    chk("mon_order_width", pulse_viol, 0);
    chk("mon_max_level", max_level, FD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_output_seq.md
Name: io_output_seq

Overview:
- Parametrised, buffered successor of the output half of the I/O electronic unit.
- Serialises a number held in ac/au into a sign code, N digit codes and an end code, then sends them to the output device over a four-phase rdy/ack handshake.
- A code FIFO decouples digit fetch (order_io/ac_answer with ac) from the slow device. Digit counts, FIFO depth and end code are parameters.
- Sits between ac/au and the printer/punch; issues the automatic start pulse to pu when finished.

Parameters:
OCT_DIGITS, 10, digits emitted in octal mode (1..15)
DEC_DIGITS, 7, digits emitted in decimal mode (1..15)
FIFO_DEPTH, 4, code FIFO entries (power of 2, >=2)
END_CODE, 5'b00110, code emitted after the last digit

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start_output  in  1  pulse, begin a number
stop_output  in  1  pulse, abort
mode_oct  in  1  level, octal mode, sampled on accepted start
mode_dec  in  1  level, decimal mode, sampled on accepted start
stop_after_output  in  1  level, suppress start pulse at finish
output_sign_from_ac  in  1  sign bit
output_data_from_au  in  4  current digit
order_io_to_ac  out  1  pulse, request next digit shift
ac_answer_from_ac  in  1  pulse, digit valid on output_data_from_au
shift_3_bit_to_ac  out  1  level, active && octal
shift_4_bit_to_ac  out  1  level, active && decimal
output_active  out  1  level, sequence in progress
output_rdy_to_dev  out  1  handshake
output_ack_from_dev  in  1  handshake
output_data_to_dev  out  5  FIFO head code
start_pulse_to_pu  out  1  pulse, sequence finished
fifo_level  out  clog2(FIFO_DEPTH+1)  occupied entries

Behaviour:
- Reset: all outputs 0. Producer in P_IDLE, device side in D_IDLE, FIFO empty, digit counter 0, mode register clear.

Producer FSM:
- P_IDLE: start_output is accepted if mode_oct or mode_dec is high.
  - mode_oct wins when both are high; neither high means start is ignored.
  - On accept: latch mode, N = OCT_DIGITS or DEC_DIGITS, cnt=0, output_active=1 next cycle, go to P_SIGN.
- P_SIGN: if FIFO not full, push {4'b1111, output_sign_from_ac}, go to P_REQ; otherwise hold.
- P_REQ: order_io_to_ac=1 for exactly this cycle, go to P_WAIT.
- P_WAIT: on ac_answer_from_ac, capture output_data_from_au into a hold register and go to P_NUM.
- P_NUM: if FIFO not full, push the code, cnt+1, then go to P_END if cnt+1==N, else P_REQ.
  - Octal code: {2'b10, d[3:1]}. Decimal code: {1'b1, d[3:0]}.
- P_END: if FIFO not full, push END_CODE, go to P_DRAIN.
- P_DRAIN: when FIFO empty and device side in D_IDLE:
  - output_active clears next cycle.
  - start_pulse_to_pu=1 for one cycle unless stop_after_output.
  - Go to P_IDLE.

Device FSM:
- D_IDLE: if FIFO non-empty, go to D_RDY.
- D_RDY: output_rdy_to_dev=1 and output_data_to_dev=head. On ack high, go to D_ACK.
- D_ACK: rdy=0, data held. On ack low, pop the head and go to D_IDLE.
- rdy is low for at least one cycle between codes.
- output_data_to_dev is 0 when the FIFO is empty.

FIFO:
- Push and pop in the same cycle: level unchanged.
- Full: producer stalls in its push state.
- Pointers wrap modulo FIFO_DEPTH.

Timing:
- start_output sampled in cycle 0: P_SIGN and push in cycle 1, fifo_level=1 in cycle 2, rdy=1 in cycle 3 (empty FIFO, D_IDLE).

Abort (stop_output in any non-idle state):
- Next cycle: P_IDLE, FIFO flushed, output_active=0, no start pulse, pending ac_answer ignored.
- D_RDY goes to D_IDLE. D_ACK waits for ack low, then D_IDLE, with no pop.
- stop_output in P_IDLE: no effect.

Other rules:
- start_output while active: ignored.
- stop_output and start_output in the same cycle: stop wins, start ignored.
- ac_answer outside P_WAIT: ignored.
- Mode inputs changing mid-sequence: no effect.
- Reset mid-operation: immediate return to reset state, including from D_ACK.

Test Plan:
- mode_dec, sign=1, au digits 1..7 answered 2 cycles after each order_io, device acks immediately:
  - Device receives 5'b11111, 10001..10111, 00110.
  - Exactly 7 order_io pulses, one start_pulse_to_pu, output_active low afterwards.
- mode_oct, sign=0, digits d=4'b1110 each:
  - Codes 11110, then 10 × 10111, then 00110.
  - shift_3_bit_to_ac high throughout, shift_4_bit_to_ac low.
- Device holds ack off for 50 cycles, FIFO_DEPTH=4:
  - fifo_level saturates at 4, producer stalls with no order_io while full.
  - All codes later delivered in order, none lost.
- stop_output while in D_ACK with 3 codes queued:
  - fifo_level=0 next cycle, no start pulse, rdy stays 0 after ack drops.
  - A new start then yields a clean sign code first.
- stop_after_output=1 in a decimal run: all codes delivered, start_pulse_to_pu never asserted.
- start_output with mode_oct=mode_dec=0, and start_output during an active run: both ignored, no order_io, no extra codes.
